// File: rtl/sram.sv
// Single-port synchronous SRAM with registered read data and a zero-fill
// sweep after reset; busy stays high until every word has been cleared.
module sram #(
  parameter  int DEPTH   = 16,
  parameter  int WIDTH   = 8,
  localparam int DEPTH_B = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               we,
  input  logic [DEPTH_B-1:0] ad,
  input  logic [WIDTH-1:0]   wd,
  output logic [WIDTH-1:0]   rd,
  output logic               busy
);

  localparam logic [DEPTH_B:0]   DEPTH_L = (DEPTH_B+1)'(DEPTH);
  localparam logic [DEPTH_B-1:0] LAST    = DEPTH_B'(DEPTH-1);

  typedef struct packed {
    logic               en;
    logic [DEPTH_B-1:0] addr;
    logic [WIDTH-1:0]   data;
  } wr_t;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_B-1:0] swp;
  logic               in_rng;
  wr_t                wr;

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
  assign in_rng = ({1'b0, ad} < DEPTH_L);

  // Single write port shared by the sweep and user writes; sweep has priority.
  always_comb begin
    wr = '0;
    if (!rst) begin
      if (busy) begin
        wr.en   = 1'b1;
        wr.addr = swp;
      end else if (cs && we && in_rng) begin
        wr.en   = 1'b1;
        wr.addr = ad;
        wr.data = wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd   <= '0;
      busy <= 1'b1;
      swp  <= '0;
    end else if (busy) begin
      rd <= '0;
      if (swp == LAST) busy <= 1'b0;
      else             swp  <= swp + DEPTH_B'(1);
    end else if (cs && !we) begin
      rd <= in_rng ? mem[ad] : '0;
    end
  end

endmodule

// File: tb/tb_sram.sv
// Scoreboard bench for sram: a 16-deep instance for the main function and a
// 10-deep instance for out-of-range addressing.
module tb_sram;

  logic       clk = 1'b0;
  logic       rst, cs, we;
  logic [3:0] ad;
  logic [7:0] wd, rd;
  logic       busy;

  logic       rst2, cs2, we2;
  logic [3:0] ad2;
  logic [7:0] wd2, rd2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  logic [7:0] model  [16];
  logic [7:0] model2 [10];
  logic [7:0] exp_q  [$];
  logic [7:0] exp_q2 [$];
  logic [7:0] e;

  sram #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .ad(ad), .wd(wd), .rd(rd), .busy(busy)
  );

  sram #(.DEPTH(10), .WIDTH(8)) dut10 (
    .clk(clk), .rst(rst2), .cs(cs2), .we(we2), .ad(ad2), .wd(wd2), .rd(rd2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; cs = 1'b0; we = 1'b0; ad = '0; wd = '0;
    cyc(); cyc();
    checks++;
    if (rd !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state rd=%h busy=%b expected rd=00 busy=1", rd, busy);
    end
    // release with a read and a write driven; both must be ignored
    rst = 1'b0; cs = 1'b1; we = 1'b1; ad = 4'd1; wd = 8'h77;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) begin we = 1'b0; ad = 4'd2; end
      cyc();
      checks++;
      if (rd !== 8'h00) begin
        errors++;
        $display("FAIL sweep_rd edge=%0d rd=%h expected 00", k, rd);
      end
      if (busy !== 1'b1) begin
        n = k;
        break;
      end
    end
    cs = 1'b0; we = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL sweep_len busy fell after edge %0d expected 16", n);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
  endtask

  task automatic test_zero_reads();
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; we = 1'b0; ad = 4'(i);
      exp_q.push_back(model[i]);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
        errors++;
        $display("FAIL zero_read ad=%0d rd=%h expected %h", i, rd, e);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; we = 1'b1; ad = 4'(i); wd = 8'(i);
      model[i] = 8'(i);
      cyc();
      checks++;
      if (rd !== 8'h00) begin
        errors++;
        $display("FAIL write_keeps_rd ad=%0d rd=%h expected 00", i, rd);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; we = 1'b0; ad = 4'(i);
      exp_q.push_back(model[i]);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
        errors++;
        $display("FAIL b2b_read ad=%0d rd=%h expected %h", i, rd, e);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_hold();
    cs = 1'b1; we = 1'b0; ad = 4'd7;
    exp_q.push_back(model[7]);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL hold_setup rd=%h expected %h", rd, e);
    end
    we = 1'b1; ad = 4'd3; wd = 8'hA5;
    model[3] = 8'hA5;
    cyc();
    cs = 1'b0; we = 1'b0; ad = 4'd3;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd !== 8'h07) begin
        errors++;
        $display("FAIL hold_rd step=%0d rd=%h expected 07", k, rd);
      end
      if (k < 3) cyc();
    end
    cs = 1'b1; we = 1'b0; ad = 4'd3;
    exp_q.push_back(model[3]);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL hold_read ad=3 rd=%h expected %h", rd, e);
    end
    cs = 1'b0;
  endtask

  task automatic test_cs_gate();
    cs = 1'b0; we = 1'b1; ad = 4'd5; wd = 8'hFF;
    cyc();
    cs = 1'b1; we = 1'b0; ad = 4'd5;
    exp_q.push_back(model[5]);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL cs_gate ad=5 rd=%h expected %h", rd, e);
    end
    // write then read the same address on the very next cycle
    we = 1'b1; ad = 4'd4; wd = 8'h44;
    model[4] = 8'h44;
    cyc();
    we = 1'b0;
    exp_q.push_back(model[4]);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL raw ad=4 rd=%h expected %h", rd, e);
    end
    cs = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    cs = 1'b1; we = 1'b1; ad = 4'd9; wd = 8'h3C;
    cyc();
    // reset while a read of the fresh data is being requested aborts it
    we = 1'b0; rst = 1'b1;
    cyc();
    checks++;
    if (rd !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort rd=%h busy=%b expected rd=00 busy=1", rd, busy);
    end
    rst = 1'b0; cs = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (busy !== 1'b1) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL restart_len busy fell after edge %0d expected 16", n);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    cs = 1'b1; we = 1'b0; ad = 4'd9;
    exp_q.push_back(model[9]);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL restart_read ad=9 rd=%h expected %h", rd, e);
    end
    cs = 1'b0;
  endtask

  task automatic test_out_of_range();
    int n;
    logic [3:0] rd_ad [4];
    rst2 = 1'b1; cs2 = 1'b0; we2 = 1'b0; ad2 = '0; wd2 = '0;
    cyc(); cyc();
    rst2 = 1'b0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (busy2 !== 1'b1) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL sweep10_len busy fell after edge %0d expected 10", n);
    end
    for (int i = 0; i < 10; i++) model2[i] = 8'h00;
    cs2 = 1'b1; we2 = 1'b1; ad2 = 4'd12; wd2 = 8'h5A;
    cyc();
    ad2 = 4'd9; wd2 = 8'h99;
    model2[9] = 8'h99;
    cyc();
    ad2 = 4'd2; wd2 = 8'h22;
    model2[2] = 8'h22;
    cyc();
    rd_ad[0] = 4'd12; rd_ad[1] = 4'd9; rd_ad[2] = 4'd15; rd_ad[3] = 4'd2;
    we2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ad2 = rd_ad[i];
      exp_q2.push_back(rd_ad[i] < 4'd10 ? model2[rd_ad[i]] : 8'h00);
      cyc();
      e = exp_q2.pop_front();
      checks++;
      if (rd2 !== e) begin
        errors++;
        $display("FAIL oor_read ad=%0d rd=%h expected %h", rd_ad[i], rd2, e);
      end
    end
    cs2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; ad = '0; wd = '0;
    rst2 = 1'b1; cs2 = 1'b0; we2 = 1'b0; ad2 = '0; wd2 = '0;
    test_reset();
    test_zero_reads();
    test_back_to_back();
    test_hold();
    test_cs_gate();
    test_reset_mid();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
